sr_fetch_ctrl: RTL and testbench

- Multi-cycle instruction fetch controller for schoolRISCV.
- Sequences the program counter and issues one instruction-memory request at a time over a req/gnt + rvalid handshake.
- Buffers the returned word and presents it to the decode stage (sr_decode input) with a valid/ready handshake.
- Handles branch/jump redirects from execute, including killing in-flight wrong-path fetches.

---
 rtl/sr_fetch_ctrl.sv | 106 ++++++++++
 tb/tb_sr_fetch_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sr_fetch_ctrl.sv
// Multi-cycle instruction fetch controller for schoolRISCV: one outstanding imem request at a
// time, a single-entry instruction buffer toward decode, and redirect with wrong-path kill.
module sr_fetch_ctrl #(
  parameter int unsigned            ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [ADDR_W-1:0] redir_pc;

  assign redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    kill_d     = kill_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    unique case (state_q)
      StIdle: begin
        state_d = StReq;
        if (redirect) pc_d = redir_pc;
      end
      StReq: begin
        if (redirect) pc_d = redir_pc;
        // A redirect in the grant cycle leaves a wrong-path request in flight.
        if (imem_gnt) begin
          state_d = StWait;
          kill_d  = redirect;
        end
      end
      StWait: begin
        if (redirect) begin
          pc_d   = redir_pc;
          kill_d = 1'b1;
        end
        if (imem_rvalid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = StReq;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            state_d    = StHold;
          end
        end
      end
      StHold: begin
        // Redirect wins over a simultaneous consume.
        if (redirect) begin
          pc_d    = redir_pc;
          state_d = StReq;
        end else if (instr_ready) begin
          pc_d    = pc_q + ADDR_W'(4);
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req    = (state_q == StReq);
    instr_valid = (state_q == StHold);
    imem_addr   = {pc_q[ADDR_W-1:2], 2'b00};
    instr       = instr_q;
    instr_pc    = instr_pc_q;
  end

endmodule

// File: tb/tb_sr_fetch_ctrl.sv
// Randomized bench for sr_fetch_ctrl: a memory responder plus a transaction-level model of the
// fetch stream (expected fetch PC, outstanding request, buffered instruction).
module tb_sr_fetch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready, redirect;
  logic [31:0] instr, instr_pc, redirect_pc;

  sr_fetch_ctrl #(.ADDR_W(32), .RESET_PC(RPC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_ready(instr_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE11;
  endfunction

  // Reference model: transaction view of the fetch stream.
  bit          m_fresh, m_busy, m_live, m_hold;
  logic [31:0] m_pc, m_gaddr, m_hpc, m_hword;
  // Memory responder.
  bit          mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;
  // Stimulus knobs.
  int          p_gnt, p_ready, p_redir, p_spur, max_lat, p_rst;
  bit          force_rst, log_grants;
  int          cyc;
  int          g_cyc[$];
  logic [31:0] g_addr[$];

  task automatic model_reset();
    m_fresh = 1; m_busy = 0; m_live = 0; m_hold = 0; m_pc = RPC;
    mem_pend = 0;
  endtask

  task automatic drive_inputs();
    imem_gnt    = ($urandom_range(99) < p_gnt);
    instr_ready = ($urandom_range(99) < p_ready);
    redirect    = ($urandom_range(99) < p_redir);
    case ($urandom_range(3))
      0:       redirect_pc = 32'hFFFF_FFFE;
      1:       redirect_pc = $urandom;
      default: redirect_pc = 32'h0000_0000 | 32'($urandom_range(4095));
    endcase
    if (mem_pend && mem_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_addr);
    end else begin
      imem_rvalid = !mem_pend && ($urandom_range(99) < p_spur);
      imem_rdata  = $urandom;
    end
    rst = force_rst || ($urandom_range(999) < p_rst);
  endtask

  task automatic check_outputs();
    bit req_exp;
    req_exp = !m_fresh && !m_busy && !m_hold;
    check("imem_req", imem_req, req_exp);
    check("imem_addr", imem_addr, m_pc);
    check("instr_valid", instr_valid, m_hold);
    if (m_hold) begin
      check("instr", instr, m_hword);
      check("instr_pc", instr_pc, m_hpc);
    end
  endtask

  task automatic update_model();
    bit req_exp;
    if (rst) mem_pend = 0;
    else if (imem_req && imem_gnt) begin
      mem_pend = 1;
      mem_cnt  = int'($urandom_range(max_lat - 1));
      mem_addr = imem_addr;
    end else if (mem_pend) begin
      if (imem_rvalid) mem_pend = 0;
      else mem_cnt--;
    end
    if (log_grants && imem_req && imem_gnt) begin
      g_cyc.push_back(cyc);
      g_addr.push_back(imem_addr);
    end

    if (rst) begin
      m_fresh = 1; m_busy = 0; m_hold = 0; m_pc = RPC;
    end else begin
      req_exp = !m_fresh && !m_busy && !m_hold;
      m_fresh = 0;
      if (req_exp && imem_gnt) begin
        m_busy  = 1;
        m_live  = !redirect;
        m_gaddr = m_pc;
      end else if (m_busy && imem_rvalid) begin
        m_busy = 0;
        if (m_live && !redirect) begin
          m_hold  = 1;
          m_hpc   = m_gaddr;
          m_hword = mem_word(m_gaddr);
        end
      end else if (m_hold && !redirect && instr_ready) begin
        m_hold = 0;
        m_pc   = m_pc + 32'd4;
      end
      if (redirect) begin
        m_live = 0;
        m_hold = 0;
        m_pc   = {redirect_pc[31:2], 2'b00};
      end
    end
  endtask

  task automatic step();
    #1;
    drive_inputs();
    #4;
    check_outputs();
    update_model();
    cyc++;
    @(posedge clk);
  endtask

  initial begin
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    instr_ready = 0; redirect = 0; redirect_pc = '0;
    force_rst = 0; log_grants = 0; cyc = 1;
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    #1;
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);

    // Zero-wait memory, decode always ready: 3 cycles per instruction.
    p_gnt = 100; p_ready = 100; p_redir = 0; p_spur = 0; max_lat = 1; p_rst = 0;
    log_grants = 1;
    repeat (12) step();
    log_grants = 0;
    check("n_grants", 32'(g_cyc.size()), 32'd4);
    for (int i = 0; i < 3 && i < g_cyc.size(); i++) begin
      check("grant_cycle", 32'(g_cyc[i]), 32'(2 + 3 * i));
      check("grant_addr", g_addr[i], RPC + 32'(4 * i));
    end

    // Reset while a fetch is in flight.
    p_gnt = 50; max_lat = 3;
    for (int i = 0; i < 20 && !m_busy; i++) step();
    check("busy_before_rst", 32'(m_busy), 32'd1);
    force_rst = 1;
    step();
    force_rst = 0;
    step();

    for (int ph = 0; ph < 10; ph++) begin
      p_gnt   = 20 + int'($urandom_range(80));
      p_ready = 20 + int'($urandom_range(80));
      p_redir = int'($urandom_range(15));
      p_spur  = int'($urandom_range(20));
      max_lat = 1 + int'($urandom_range(3));
      p_rst   = int'($urandom_range(5));
      repeat (300) step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
